// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder with a single registered output stage.
// A chain of WIDTH full-adder cells feeds a capture register. The register is
// qualified by in_valid, so the result appears one cycle after an accepted input.
// Optional feature macro: RIPPLE_CARRY_ADDER_OVF_EN adds a registered
// two's-complement overflow output, ovf.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Explicit full-adder cell chain, LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p      = in1[i] ^ in2[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (in1[i] & in2[i]) | (c[i] & p);
    end

    // Output register: capture on an accepted cycle, otherwise hold data and drop valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    // Signed overflow: the carry into the sign bit differs from the carry out of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH=4 and WIDTH=8 instances).
// Expected values come from plain integer arithmetic on the operands.
module tb_ripple_carry_adder;

    logic       clock;
    logic       reset_n;

    logic       v4, ci4;
    logic [3:0] a4, b4;
    logic [3:0] sum4;
    logic       co4, val4;
    logic       ov4;

    logic       v8, ci8;
    logic [7:0] a8, b8;
    logic [7:0] sum8;
    logic       co8, val8;
    logic       ov8;

    int checks = 0;
    int errors = 0;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (v4),
        .in1       (a4),
        .in2       (b4),
        .cin       (ci4),
        .sum       (sum4),
        .cout      (co4),
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        .ovf       (ov4),
`endif
        .out_valid (val4)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (v8),
        .in1       (a8),
        .in2       (b8),
        .cin       (ci8),
        .sum       (sum8),
        .cout      (co8),
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        .ovf       (ov8),
`endif
        .out_valid (val8)
    );

`ifndef RIPPLE_CARRY_ADDER_OVF_EN
    assign ov4 = 1'b0;
    assign ov8 = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: unsigned sum/carry of a+b+cin at width w.
    function automatic int unsigned ref_add(int w, int unsigned a, int unsigned b, bit ci);
        int unsigned r;
        r = a + b + ci;
        return r & ((1 << (w + 1)) - 1);
    endfunction

    // Reference: does the signed sum fall outside the w-bit two's-complement range?
    function automatic bit ref_ovf(int w, int unsigned a, int unsigned b, bit ci);
        int sa, sb, s;
        sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        s  = sa + sb + int'(ci);
        return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    endfunction

    task automatic drive4(input bit v, input logic [3:0] a, input logic [3:0] b, input bit ci);
        @(negedge clock);
        v4 = v; a4 = a; b4 = b; ci4 = ci;
    endtask

    task automatic test_reset();
        // Outputs are cleared while reset is held from time zero.
        #1;
        checks++;
        if ({sum4, co4, val4, ov4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_initial: got sum=%b cout=%b valid=%b ovf=%b, want all 0",
                     sum4, co4, val4, ov4);
        end
        @(negedge clock);
        reset_n = 1'b1;
        // Load a nonzero result, then pull reset between edges.
        drive4(1'b1, 4'b1111, 4'b1111, 1'b1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({sum4, co4, val4, ov4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got sum=%b cout=%b valid=%b ovf=%b, want all 0",
                     sum4, co4, val4, ov4);
        end
        // A pending valid input during reset must be discarded.
        @(posedge clock);
        #1;
        checks++;
        if ({sum4, co4, val4, ov4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_pending: got sum=%b cout=%b valid=%b ovf=%b, want all 0",
                     sum4, co4, val4, ov4);
        end
        @(negedge clock);
        reset_n = 1'b1;
        v4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] ta [4];
        logic [3:0] tb [4];
        bit         tc [4];
        logic [3:0] es [4];
        bit         ec [4];
        bit         eo [4];
        ta = '{4'b1101, 4'b1010, 4'b0111, 4'b1111};
        tb = '{4'b1000, 4'b1001, 4'b0001, 4'b0000};
        tc = '{1'b1, 1'b0, 1'b0, 1'b1};
        es = '{4'b0110, 4'b0011, 4'b1000, 4'b0000};
        ec = '{1'b1, 1'b1, 1'b0, 1'b1};
        eo = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, ta[i], tb[i], tc[i]);
            @(posedge clock);
            #1;
            checks++;
            if ({co4, sum4, val4} !== {ec[i], es[i], 1'b1}) begin
                errors++;
                $display("FAIL b2b_vec%0d: got cout=%b sum=%b valid=%b, want cout=%b sum=%b valid=1",
                         i, co4, sum4, val4, ec[i], es[i]);
            end
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
            checks++;
            if (ov4 !== eo[i]) begin
                errors++;
                $display("FAIL b2b_ovf%0d: got ovf=%b, want %b", i, ov4, eo[i]);
            end
`endif
        end
    endtask

    task automatic test_hold();
        // Follows the wrap vector 1111+0000+1 -> sum=0000 cout=1 ovf=0.
        for (int i = 0; i < 2; i++) begin
            drive4(1'b0, 4'b0101, (i == 0) ? 4'bxxxx : 4'b1111, 1'bx);
            @(posedge clock);
            #1;
            checks++;
            if ({co4, sum4, val4, ov4} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold%0d: got cout=%b sum=%b valid=%b ovf=%b, want 1 0000 0 0",
                         i, co4, sum4, val4, ov4);
            end
        end
    endtask

    task automatic test_exhaustive4();
        int unsigned r;
        bit          eo;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(1'b1, 4'(a), 4'(b), c[0]);
                    @(posedge clock);
                    #1;
                    r  = ref_add(4, a, b, c[0]);
                    eo = ref_ovf(4, a, b, c[0]);
`ifndef RIPPLE_CARRY_ADDER_OVF_EN
                    eo = 1'b0;
`endif
                    checks++;
                    if ({co4, sum4, val4, ov4} !== {r[4:0], 1'b1, eo}) begin
                        errors++;
                        $display("FAIL exh4 a=%0d b=%0d c=%0d: got %b%b v=%b o=%b, want %b v=1 o=%b",
                                 a, b, c, co4, sum4, val4, ov4, r[4:0], eo);
                    end
                end
            end
        end
        drive4(1'b0, 4'b0, 4'b0, 1'b0);
    endtask

    task automatic test_random8();
        int unsigned a, b, r;
        bit          c, v, eo;
        logic [8:0]  exp_res;
        bit          exp_ovf;
        exp_res = '0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(255);
            b = $urandom_range(255);
            c = 1'($urandom_range(1));
            v = ($urandom_range(3) != 0);
            @(negedge clock);
            v8 = v; a8 = 8'(a); b8 = 8'(b); ci8 = c;
            @(posedge clock);
            #1;
            if (v) begin
                r       = ref_add(8, a, b, c);
                eo      = ref_ovf(8, a, b, c);
                exp_res = r[8:0];
                exp_ovf = eo;
            end
`ifndef RIPPLE_CARRY_ADDER_OVF_EN
            exp_ovf = 1'b0;
`endif
            checks++;
            if ({co8, sum8, val8, ov8} !== {exp_res, v, exp_ovf}) begin
                errors++;
                $display("FAIL rnd8 #%0d a=%0d b=%0d c=%0d v=%0d: got %b%b v=%b o=%b, want %b v=%b o=%b",
                         i, a, b, c, v, co8, sum8, val8, ov8, exp_res, v, exp_ovf);
            end
        end
        @(negedge clock);
        v8 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        v4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_exhaustive4();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised ripple-carry adder: WIDTH chained full-adder cells, carry propagating from LSB to MSB.
- One output register stage gives a 1-cycle result latency, so the block drops into clocked datapaths (ALU/PC-increment paths of the MIPS core).
- Simple valid qualifier on input and output. No backpressure.

Parameters:
- WIDTH, 4, operand and sum bit width; legal range 1 to 32.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and carry-in are valid this cycle.
- in1  input  WIDTH  operand A, unsigned (two's complement when the overflow feature is used).
- in2  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  sum/cout hold a result captured on the previous accepted cycle.

Behaviour:
- Datapath: full-adder cell i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = cin; cout_comb = c[WIDTH].
  - Build it as an explicit cell chain (generate loop or instances), not a single behavioural "+".
- Arithmetic: {cout_comb, s} = in1 + in2 + cin, exact and modulo 2^(WIDTH+1). No saturation.
- Reset: when reset_n is low, sum=0, cout=0 and out_valid=0 immediately, independent of clock.
  - Reset asserted mid-operation discards any pending result.
  - The first capture is possible on the first rising edge after reset_n deasserts.
- Capture: on a rising edge with in_valid=1, sum<=s, cout<=cout_comb, out_valid<=1.
- Hold: on a rising edge with in_valid=0, sum and cout hold their previous values and out_valid<=0.
- Latency: exactly 1 cycle. Back-to-back in_valid each cycle gives one result per cycle, with no bubbles.
- X/undriven operands while in_valid=0 must not affect the outputs.
- Wrap-around: all-ones + all-zeros + cin=1 gives sum=0, cout=1.

Optional Feature:
- Macro: RIPPLE_CARRY_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the registered two's-complement overflow, computed as c[WIDTH] ^ c[WIDTH-1].
  - ovf is captured and held under exactly the same rules as cout.
  - ovf resets to 0.
- Not defined: port ovf does not exist and no overflow logic is synthesised. Everything else is identical.

Test Plan:
- Reset: assert reset_n=0 asynchronously between edges with prior nonzero outputs -> sum=0, cout=0, out_valid=0 (ovf=0) immediately.
- WIDTH=4, in1=1101, in2=1000, cin=1, in_valid=1 -> next edge: sum=0110, cout=1, out_valid=1, ovf=1.
- Back-to-back: next cycle in1=1010, in2=1001, cin=0 -> sum=0011, cout=1, ovf=1, result one cycle after the prior one.
- Positive overflow: in1=0111, in2=0001, cin=0 -> sum=1000, cout=0, ovf=1.
- Wrap: in1=1111, in2=0000, cin=1 -> sum=0000, cout=1, ovf=0. Then in_valid=0 with in1=0101 -> sum/cout unchanged, out_valid=0.
- Exhaustive: WIDTH=4, all 512 (in1, in2, cin) combinations -> {cout,sum} equals the reference add each time. Repeat with WIDTH=8 on random vectors.
